// File: rtl/mem_arbiter_if.sv
// Bus bundle tying the fetch port, the data port and the shared single-port memory
// to the arbiter; the arbiter owns the master view, the CPU/memory side the slave view.
interface mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt;
    logic [DW-1:0] f_rdata;
    logic          f_rvalid;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic [DW-1:0] d_rdata;
    logic          d_rvalid;

    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport master (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output f_gnt, f_rdata, f_rvalid, d_gnt, d_rdata, d_rvalid,
        output mem_read, mem_write, mem_addr, mem_wdata, busy
    );

    modport slave (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  f_gnt, f_rdata, f_rvalid, d_gnt, d_rdata, d_rvalid,
        input  mem_read, mem_write, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port memory:
// one-cycle accesses, round-robin on ties, back-to-back grants between ports.
module mem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        F_ACC = 2'd1,
        D_ACC = 2'd2
    } state_t;

    localparam logic GNT_F = 1'b0;
    localparam logic GNT_D = 1'b1;

    state_t        state_r;
    logic          last_gnt_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] wdata_r;
    logic          we_r;
    logic          f_gnt_r;
    logic          d_gnt_r;
    logic          mem_read_r;
    logic          mem_write_r;
    logic          busy_r;
    logic [DW-1:0] f_rdata_r;
    logic [DW-1:0] d_rdata_r;
    logic          f_rvalid_r;
    logic          d_rvalid_r;
    logic          pick_f_s;
    logic          pick_d_s;

    // Winner of the next access; the port being served right now is never re-picked
    always_comb begin
        pick_f_s = 1'b0;
        pick_d_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.f_req && bus.d_req) begin
                    pick_f_s = (last_gnt_r == GNT_D);
                    pick_d_s = (last_gnt_r == GNT_F);
                end else begin
                    pick_f_s = bus.f_req;
                    pick_d_s = bus.d_req;
                end
            end
            F_ACC:   pick_d_s = bus.d_req;
            D_ACC:   pick_f_s = bus.f_req;
            default: begin
                pick_f_s = 1'b0;
                pick_d_s = 1'b0;
            end
        endcase
    end

    // Access FSM with registered grants, memory strobes and read-data capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            last_gnt_r  <= GNT_D;
            addr_r      <= {AW{1'b0}};
            wdata_r     <= {DW{1'b0}};
            we_r        <= 1'b0;
            f_gnt_r     <= 1'b0;
            d_gnt_r     <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            busy_r      <= 1'b0;
            f_rdata_r   <= {DW{1'b0}};
            d_rdata_r   <= {DW{1'b0}};
            f_rvalid_r  <= 1'b0;
            d_rvalid_r  <= 1'b0;
        end else begin
            f_rvalid_r <= 1'b0;
            d_rvalid_r <= 1'b0;
            // The access cycle ends at this edge, so memory read data is sampled now
            case (state_r)
                F_ACC: begin
                    f_rdata_r  <= bus.mem_rdata;
                    f_rvalid_r <= 1'b1;
                end
                D_ACC: begin
                    if (!we_r) begin
                        d_rdata_r  <= bus.mem_rdata;
                        d_rvalid_r <= 1'b1;
                    end
                end
                default: begin
                end
            endcase

            if (pick_f_s) begin
                state_r     <= F_ACC;
                last_gnt_r  <= GNT_F;
                addr_r      <= bus.f_addr;
                we_r        <= 1'b0;
                f_gnt_r     <= 1'b1;
                d_gnt_r     <= 1'b0;
                mem_read_r  <= 1'b1;
                mem_write_r <= 1'b0;
                busy_r      <= 1'b1;
            end else if (pick_d_s) begin
                state_r     <= D_ACC;
                last_gnt_r  <= GNT_D;
                addr_r      <= bus.d_addr;
                wdata_r     <= bus.d_wdata;
                we_r        <= bus.d_we;
                f_gnt_r     <= 1'b0;
                d_gnt_r     <= 1'b1;
                mem_read_r  <= !bus.d_we;
                mem_write_r <= bus.d_we;
                busy_r      <= 1'b1;
            end else begin
                state_r     <= IDLE;
                f_gnt_r     <= 1'b0;
                d_gnt_r     <= 1'b0;
                mem_read_r  <= 1'b0;
                mem_write_r <= 1'b0;
                busy_r      <= 1'b0;
            end
        end
    end

    assign bus.f_gnt     = f_gnt_r;
    assign bus.f_rdata   = f_rdata_r;
    assign bus.f_rvalid  = f_rvalid_r;
    assign bus.d_gnt     = d_gnt_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.d_rvalid  = d_rvalid_r;
    assign bus.mem_read  = mem_read_r;
    assign bus.mem_write = mem_write_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single accesses plus hand-written
// tie, back-to-back and reset-abort sequences; read data is scoreboarded by cycle.
module tb_mem_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    logic preload;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    mem_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: content ~addr, except 0x05 = 0xA3; writes sampled at the rising edge
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i == 5) ? 8'hA3 : ~8'(i);
        end else if (bus.mem_write) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr] : 8'h00;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t fq[$];
    exp_t dq[$];
    exp_t fe;
    exp_t de;

    typedef struct {
        logic          is_d;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          exp_rv;
        logic [DW-1:0] exp_rdata;
    } vec_t;
    vec_t vecs[11];

    function automatic void check(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] @cyc %0d: got %0h, expected %0h", name, idx, cyc, act, exp);
        end
    endfunction

    function automatic void push_exp(logic is_d, logic [DW-1:0] data, int at_cyc);
        exp_t e;
        e.data = data;
        e.cyc  = at_cyc;
        if (is_d) dq.push_back(e);
        else fq.push_back(e);
    endfunction

    // Continuous exclusivity checks and cycle-exact read-data scoreboard
    always @(negedge clk) begin
        check("rw_exclusive", 0, {31'd0, bus.mem_read & bus.mem_write}, 32'd0);
        check("gnt_exclusive", 0, {31'd0, bus.f_gnt & bus.d_gnt}, 32'd0);
        if (fq.size() != 0 && fq[0].cyc == cyc) begin
            fe = fq.pop_front();
            check("f_rvalid", fe.cyc, {31'd0, bus.f_rvalid}, 32'd1);
            check("f_rdata", fe.cyc, {24'd0, bus.f_rdata}, {24'd0, fe.data});
        end else begin
            check("f_rvalid_quiet", cyc, {31'd0, bus.f_rvalid}, 32'd0);
        end
        if (dq.size() != 0 && dq[0].cyc == cyc) begin
            de = dq.pop_front();
            check("d_rvalid", de.cyc, {31'd0, bus.d_rvalid}, 32'd1);
            check("d_rdata", de.cyc, {24'd0, bus.d_rdata}, {24'd0, de.data});
        end else begin
            check("d_rvalid_quiet", cyc, {31'd0, bus.d_rvalid}, 32'd0);
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        if (v.is_d) begin
            bus.d_req   = 1'b1;
            bus.d_we    = v.we;
            bus.d_addr  = v.addr;
            bus.d_wdata = v.wdata;
        end else begin
            bus.f_req  = 1'b1;
            bus.f_addr = v.addr;
        end
        if (v.exp_rv) push_exp(v.is_d, v.exp_rdata, cyc + 2);
        @(posedge clk);
        #1;
        check("v_f_gnt", idx, {31'd0, bus.f_gnt}, {31'd0, !v.is_d});
        check("v_d_gnt", idx, {31'd0, bus.d_gnt}, {31'd0, v.is_d});
        check("v_mem_addr", idx, {24'd0, bus.mem_addr}, {24'd0, v.addr});
        check("v_mem_write", idx, {31'd0, bus.mem_write}, {31'd0, v.is_d & v.we});
        check("v_mem_read", idx, {31'd0, bus.mem_read}, {31'd0, !(v.is_d & v.we)});
        if (v.is_d && v.we) check("v_mem_wdata", idx, {24'd0, bus.mem_wdata}, {24'd0, v.wdata});
        check("v_busy_acc", idx, {31'd0, bus.busy}, 32'd1);
        bus.f_req = 1'b0;
        bus.d_req = 1'b0;
        @(posedge clk);
        #1;
        check("v_busy_after", idx, {31'd0, bus.busy}, 32'd0);
        check("v_mem_write_after", idx, {31'd0, bus.mem_write}, 32'd0);
        check("v_gnt_after", idx, {30'd0, bus.f_gnt, bus.d_gnt}, 32'd0);
    endtask

    initial begin
        vec_t vld;
        int   c0;
        vecs[0]  = '{1'b0, 1'b0, 8'h05, 8'h00, 1'b1, 8'hA3};
        vecs[1]  = '{1'b1, 1'b1, 8'h10, 8'h5C, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 8'h5C};
        vecs[3]  = '{1'b0, 1'b0, 8'h10, 8'h00, 1'b1, 8'h5C};
        vecs[4]  = '{1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 8'hDF};
        vecs[5]  = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 8'h00};
        vecs[6]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 8'h00};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hFF};
        vecs[8]  = '{1'b1, 1'b1, 8'h00, 8'hC3, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hC3};
        vecs[10] = '{1'b1, 1'b0, 8'h80, 8'h00, 1'b1, 8'h7F};

        reset       = 1'b1;
        preload     = 1'b1;
        bus.f_req   = 1'b0;
        bus.f_addr  = 8'h00;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 8'h00;
        bus.d_wdata = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 0, {30'd0, bus.f_gnt, bus.d_gnt}, 32'd0);
        check("rst_rvalid", 0, {30'd0, bus.f_rvalid, bus.d_rvalid}, 32'd0);
        check("rst_strobes", 0, {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        check("rst_busy", 0, {31'd0, bus.busy}, 32'd0);
        check("rst_mem_addr", 0, {24'd0, bus.mem_addr}, 32'd0);
        check("rst_mem_wdata", 0, {24'd0, bus.mem_wdata}, 32'd0);
        check("rst_rdata", 0, {16'd0, bus.f_rdata, bus.d_rdata}, 32'd0);

        // Tie straight out of reset: F, D, F, D with busy held high
        @(negedge clk);
        reset      = 1'b0;
        preload    = 1'b0;
        bus.f_req  = 1'b1;
        bus.f_addr = 8'h05;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 8'h10;
        c0 = cyc;
        push_exp(1'b0, 8'hA3, c0 + 2);
        push_exp(1'b1, 8'hEF, c0 + 3);
        push_exp(1'b0, 8'hA3, c0 + 4);
        push_exp(1'b1, 8'hEF, c0 + 5);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("tie_f_gnt", k, {31'd0, bus.f_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("tie_d_gnt", k, {31'd0, bus.d_gnt}, (k % 2 == 1) ? 32'd1 : 32'd0);
            check("tie_mem_addr", k, {24'd0, bus.mem_addr}, (k % 2 == 0) ? 32'h05 : 32'h10);
            check("tie_busy", k, {31'd0, bus.busy}, 32'd1);
        end
        bus.f_req = 1'b0;
        bus.d_req = 1'b0;
        @(posedge clk);
        #1;
        check("tie_busy_end", 0, {31'd0, bus.busy}, 32'd0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Data request raised during the fetch access goes straight to D_ACC
        @(negedge clk);
        bus.f_req  = 1'b1;
        bus.f_addr = 8'h80;
        push_exp(1'b0, 8'h7F, cyc + 2);
        @(posedge clk);
        #1;
        check("b2b_f_gnt", 0, {31'd0, bus.f_gnt}, 32'd1);
        bus.f_req  = 1'b0;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 8'h10;
        push_exp(1'b1, 8'h5C, cyc + 2);
        @(posedge clk);
        #1;
        check("b2b_d_gnt", 0, {31'd0, bus.d_gnt}, 32'd1);
        check("b2b_f_gnt_off", 0, {31'd0, bus.f_gnt}, 32'd0);
        check("b2b_busy", 0, {31'd0, bus.busy}, 32'd1);
        check("b2b_mem_addr", 0, {24'd0, bus.mem_addr}, 32'h10);
        bus.d_req = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_busy_end", 0, {31'd0, bus.busy}, 32'd0);
        repeat (2) @(posedge clk);

        // Reset mid-store abandons the write
        @(negedge clk);
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 8'h30;
        bus.d_wdata = 8'h99;
        @(posedge clk);
        #1;
        check("abort_mem_write_on", 0, {31'd0, bus.mem_write}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_mem_write_off", 0, {31'd0, bus.mem_write}, 32'd0);
        check("abort_mem_read_off", 0, {31'd0, bus.mem_read}, 32'd0);
        check("abort_d_gnt", 0, {31'd0, bus.d_gnt}, 32'd0);
        check("abort_busy", 0, {31'd0, bus.busy}, 32'd0);
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_mem_kept", 0, {24'd0, mem[8'h30]}, 32'hCF);
        check("abort_rdata_clr", 0, {16'd0, bus.f_rdata, bus.d_rdata}, 32'd0);
        vld = '{1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 8'hCF};
        run_vec(vld, 11);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("fq_drained", 0, fq.size(), 32'd0);
        check("dq_drained", 0, dq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
